// File: rtl/axis_header_arbiter_if.sv
// Signal bundle between the header arbiter, its two requesters, the insert block
// and the insert block's output-stream monitor taps.
interface axis_header_arbiter_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    req0_valid;
    logic                    req1_valid;
    logic [DATA_WD-1:0]      req0_data;
    logic [DATA_WD-1:0]      req1_data;
    logic [DATA_BYTE_WD-1:0] req0_keep;
    logic [DATA_BYTE_WD-1:0] req1_keep;
    logic [BYTE_CNT_WD-1:0]  req0_byte_cnt;
    logic [BYTE_CNT_WD-1:0]  req1_byte_cnt;
    logic                    req0_ready;
    logic                    req1_ready;

    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
    logic                    ready_insert;

    logic                    mon_valid_out;
    logic                    mon_ready_out;
    logic                    mon_last_out;

    logic [1:0]              grant;
    logic                    busy;
    logic [15:0]             hdr_cnt;
    logic                    keep_err;

    modport master (
        input  req0_valid, req1_valid, req0_data, req1_data,
        input  req0_keep, req1_keep, req0_byte_cnt, req1_byte_cnt,
        output req0_ready, req1_ready,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_insert,
        input  mon_valid_out, mon_ready_out, mon_last_out,
        output grant, busy, hdr_cnt, keep_err
    );

    modport slave (
        output req0_valid, req1_valid, req0_data, req1_data,
        output req0_keep, req1_keep, req0_byte_cnt, req1_byte_cnt,
        input  req0_ready, req1_ready,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_insert,
        output mon_valid_out, mon_ready_out, mon_last_out,
        input  grant, busy, hdr_cnt, keep_err
    );
endinterface

// File: rtl/axis_header_arbiter.sv
// Round-robin arbiter granting one of two requesters' header per output packet;
// the grant is held until the insert block's output stream shows its last beat.
module axis_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_header_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, OFFER, WAIT_EOP} state_t;

    state_t                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic [BYTE_CNT_WD-1:0]  cnt_q, cnt_d;
    logic [1:0]              grant_q, grant_d;
    logic                    last_q, last_d;
    logic [15:0]             hdr_cnt_q, hdr_cnt_d;
    logic                    keep_err_q, keep_err_d;

    logic                    pick0, pick1, eop;
    logic [DATA_WD-1:0]      sel_data;
    logic [DATA_BYTE_WD-1:0] sel_keep, exp_keep;
    logic [BYTE_CNT_WD-1:0]  sel_cnt;

    // last_q = 1 means req1 owned the previous packet, so req0 wins a tie
    always_comb begin
        pick0    = bus.req0_valid & (~bus.req1_valid | last_q);
        pick1    = bus.req1_valid & (~bus.req0_valid | ~last_q);
        sel_data = pick1 ? bus.req1_data     : bus.req0_data;
        sel_keep = pick1 ? bus.req1_keep     : bus.req0_keep;
        sel_cnt  = pick1 ? bus.req1_byte_cnt : bus.req0_byte_cnt;
        exp_keep = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            exp_keep[i] = (i <= int'(sel_cnt));
        end
        eop = bus.mon_valid_out & bus.mon_ready_out & bus.mon_last_out;
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        data_d     = data_q;
        keep_d     = keep_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        last_d     = last_q;
        hdr_cnt_d  = hdr_cnt_q;
        keep_err_d = keep_err_q;
        case (state_q)
            IDLE: begin
                if (pick0 | pick1) begin
                    state_d = OFFER;
                    valid_d = 1'b1;
                    data_d  = sel_data;
                    keep_d  = sel_keep;
                    cnt_d   = sel_cnt;
                    grant_d = {pick1, pick0};
                    if (sel_keep != exp_keep) begin
                        keep_err_d = 1'b1;
                    end
                end
            end
            OFFER: begin
                // Registers are cleared so the insert outputs read zero while idle
                if (bus.ready_insert) begin
                    state_d   = WAIT_EOP;
                    valid_d   = 1'b0;
                    data_d    = '0;
                    keep_d    = '0;
                    cnt_d     = '0;
                    hdr_cnt_d = hdr_cnt_q + 16'd1;
                end
            end
            WAIT_EOP: begin
                if (eop) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
            last_q     <= 1'b1;
            hdr_cnt_q  <= 16'd0;
            keep_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            hdr_cnt_q  <= hdr_cnt_d;
            keep_err_q <= keep_err_d;
        end
    end

    assign bus.req0_ready      = (state_q == IDLE) & pick0;
    assign bus.req1_ready      = (state_q == IDLE) & pick1;
    assign bus.valid_insert    = valid_q;
    assign bus.data_insert     = data_q;
    assign bus.keep_insert     = keep_q;
    assign bus.byte_insert_cnt = cnt_q;
    assign bus.grant           = grant_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.hdr_cnt         = hdr_cnt_q;
    assign bus.keep_err        = keep_err_q;
endmodule

// File: tb/tb_axis_header_arbiter.sv
// Testbench for axis_header_arbiter: a directed vector table, hand-written
// keep-error and mid-packet reset sequences, then random traffic against a packet-level model.
module tb_axis_header_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_header_arbiter_if #(.DATA_WD(32)) bus();
    axis_header_arbiter #(.DATA_WD(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    // Reference model: who owns the current packet, whether its header is still on offer
    int        m_owner;
    int        m_last;
    bit        m_hdr_out;
    bit [31:0] m_data;
    bit [3:0]  m_keep;
    bit [1:0]  m_cnt;
    bit [15:0] m_hdr_cnt;
    bit        m_err;

    typedef struct {
        bit        r0v, r1v, rdy, mon;
        bit        e0, e1, ev;
        bit [1:0]  eg;
        bit [15:0] eh;
    } vec_t;

    vec_t vt[21];

    task automatic checkEq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit [3:0] maskOf(input bit [1:0] c);
        int m;
        m = (1 << (int'(c) + 1)) - 1;
        return m[3:0];
    endfunction

    task automatic modelReset();
        m_owner = -1; m_last = 1; m_hdr_out = 0;
        m_data = '0; m_keep = '0; m_cnt = '0; m_hdr_cnt = '0; m_err = 0;
    endtask

    // Requester that the model grants this cycle, -1 when none
    function automatic int modelPick();
        bit r0, r1;
        r0 = (bus.req0_valid === 1'b1);
        r1 = (bus.req1_valid === 1'b1);
        if (m_owner >= 0) return -1;
        if (r0 && r1) return 1 - m_last;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic modelUpdate();
        int p;
        bit eop;
        p = modelPick();
        eop = (bus.mon_valid_out & bus.mon_ready_out & bus.mon_last_out) === 1'b1;
        if (p >= 0) begin
            m_owner = p; m_hdr_out = 1;
            m_data = (p == 0) ? bus.req0_data : bus.req1_data;
            m_keep = (p == 0) ? bus.req0_keep : bus.req1_keep;
            m_cnt  = (p == 0) ? bus.req0_byte_cnt : bus.req1_byte_cnt;
            if (m_keep != maskOf(m_cnt)) m_err = 1;
        end else if (m_hdr_out && bus.ready_insert === 1'b1) begin
            m_hdr_out = 0;
            m_hdr_cnt = m_hdr_cnt + 16'd1;
        end else if (m_owner >= 0 && !m_hdr_out && eop) begin
            m_last = m_owner;
            m_owner = -1;
        end
    endtask

    task automatic checkOutput();
        int p;
        p = modelPick();
        checkEq("req0_ready", bus.req0_ready, p == 0);
        checkEq("req1_ready", bus.req1_ready, p == 1);
        checkEq("valid_insert", bus.valid_insert, m_hdr_out);
        checkEq("data_insert", bus.data_insert, m_hdr_out ? m_data : 32'd0);
        checkEq("keep_insert", bus.keep_insert, m_hdr_out ? m_keep : 4'd0);
        checkEq("byte_insert_cnt", bus.byte_insert_cnt, m_hdr_out ? m_cnt : 2'd0);
        checkEq("grant", bus.grant, (m_owner < 0) ? 0 : ((m_owner == 0) ? 1 : 2));
        checkEq("busy", bus.busy, m_owner >= 0);
        checkEq("hdr_cnt", bus.hdr_cnt, m_hdr_cnt);
        checkEq("keep_err", bus.keep_err, m_err);
    endtask

    task automatic applyStimulus(input bit r0v, input bit r1v,
                                 input bit [31:0] d0, input bit [31:0] d1,
                                 input bit [3:0] k0, input bit [3:0] k1,
                                 input bit [1:0] c0, input bit [1:0] c1,
                                 input bit rdy, input bit mv, input bit mr, input bit ml);
        bus.req0_valid = r0v; bus.req1_valid = r1v;
        bus.req0_data = d0; bus.req1_data = d1;
        bus.req0_keep = k0; bus.req1_keep = k1;
        bus.req0_byte_cnt = c0; bus.req1_byte_cnt = c1;
        bus.ready_insert = rdy;
        bus.mon_valid_out = mv; bus.mon_ready_out = mr; bus.mon_last_out = ml;
    endtask

    task automatic idleInputs();
        applyStimulus(L, L, 32'd0, 32'd0, 4'd0, 4'd0, 2'd0, 2'd0, L, L, L, L);
    endtask

    // Called at a negedge with inputs applied: check, clock, advance the model
    task automatic tick();
        #1;
        checkOutput();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input bit r0v, input bit r1v, input bit rdy, input bit mon,
                                input bit e0, input bit e1, input bit ev,
                                input bit [1:0] eg, input bit [15:0] eh);
        vec_t v;
        v.r0v = r0v; v.r1v = r1v; v.rdy = rdy; v.mon = mon;
        v.e0 = e0; v.e1 = e1; v.ev = ev; v.eg = eg; v.eh = eh;
        return v;
    endfunction

    initial begin
        bit [31:0] rd0, rd1;
        bit [1:0]  rc0, rc1;
        bit [3:0]  rk0, rk1;

        vt[0]  = mk(H, L, L, L, H, L, L, 2'b00, 16'd0);
        vt[1]  = mk(L, L, L, L, L, L, H, 2'b01, 16'd0);
        vt[2]  = mk(L, L, L, L, L, L, H, 2'b01, 16'd0);
        vt[3]  = mk(L, L, L, L, L, L, H, 2'b01, 16'd0);
        vt[4]  = mk(L, L, L, L, L, L, H, 2'b01, 16'd0);
        vt[5]  = mk(L, L, L, L, L, L, H, 2'b01, 16'd0);
        vt[6]  = mk(L, L, H, L, L, L, H, 2'b01, 16'd0);
        vt[7]  = mk(H, H, L, L, L, L, L, 2'b01, 16'd1);
        vt[8]  = mk(H, H, L, H, L, L, L, 2'b01, 16'd1);
        vt[9]  = mk(H, H, L, L, L, H, L, 2'b00, 16'd1);
        vt[10] = mk(H, H, L, H, L, L, H, 2'b10, 16'd1);
        vt[11] = mk(H, H, H, H, L, L, H, 2'b10, 16'd1);
        vt[12] = mk(H, H, L, L, L, L, L, 2'b10, 16'd2);
        vt[13] = mk(H, H, L, H, L, L, L, 2'b10, 16'd2);
        vt[14] = mk(H, H, L, L, H, L, L, 2'b00, 16'd2);
        vt[15] = mk(H, H, H, L, L, L, H, 2'b01, 16'd2);
        vt[16] = mk(H, H, L, H, L, L, L, 2'b01, 16'd3);
        vt[17] = mk(H, H, L, L, L, H, L, 2'b00, 16'd3);
        vt[18] = mk(H, H, H, L, L, L, H, 2'b10, 16'd3);
        vt[19] = mk(L, L, L, H, L, L, L, 2'b10, 16'd4);
        vt[20] = mk(L, L, L, L, L, L, L, 2'b00, 16'd4);

        // Directed table: first grant, stalled offer, round-robin, early last beat ignored
        rst = 1'b1;
        idleInputs();
        @(negedge clk);
        doReset();
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vt[i].r0v, vt[i].r1v, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'b0111, 4'b1111,
                          2'd2, 2'd3, vt[i].rdy, vt[i].mon, vt[i].mon, vt[i].mon);
            #1;
            checkEq("tbl_req0_ready", bus.req0_ready, vt[i].e0);
            checkEq("tbl_req1_ready", bus.req1_ready, vt[i].e1);
            checkEq("tbl_valid_insert", bus.valid_insert, vt[i].ev);
            checkEq("tbl_grant", bus.grant, vt[i].eg);
            checkEq("tbl_hdr_cnt", bus.hdr_cnt, vt[i].eh);
            checkEq("tbl_data_insert", bus.data_insert,
                    !vt[i].ev ? 32'd0 : (vt[i].eg == 2'b01 ? 32'hA5A5A5A5 : 32'h5A5A5A5A));
            tick();
        end

        // Keep mismatch from req1 is flagged, forwarded intact, and stays sticky
        doReset();
        applyStimulus(L, H, 32'd0, 32'hDEADBEEF, 4'd0, 4'b0011, 2'd0, 2'd0, L, L, L, L);
        tick();
        idleInputs();
        #1;
        checkEq("kerr_flag", bus.keep_err, 1'b1);
        checkEq("kerr_data", bus.data_insert, 32'hDEADBEEF);
        checkEq("kerr_keep", bus.keep_insert, 4'b0011);
        checkEq("kerr_cnt", bus.byte_insert_cnt, 2'd0);
        checkEq("kerr_grant", bus.grant, 2'b10);
        bus.ready_insert = 1'b1;
        tick();
        idleInputs();
        bus.mon_valid_out = 1'b1; bus.mon_ready_out = 1'b1; bus.mon_last_out = 1'b1;
        tick();
        applyStimulus(H, L, 32'h11223344, 32'd0, 4'b1111, 4'd0, 2'd3, 2'd0, L, L, L, L);
        tick();
        idleInputs();
        bus.ready_insert = 1'b1;
        tick();
        #1;
        checkEq("kerr_sticky", bus.keep_err, 1'b1);
        checkEq("kerr_hdr_cnt", bus.hdr_cnt, 16'd2);

        // Three headers delivered, reset hits in WAIT_EOP between clock edges
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(H, L, 32'hCAFE0000 + 32'(k), 32'd0, 4'b0001, 4'd0, 2'd0, 2'd0, L, L, L, L);
            tick();
            idleInputs();
            bus.ready_insert = 1'b1;
            tick();
            if (k < 2) begin
                idleInputs();
                bus.mon_valid_out = 1'b1; bus.mon_ready_out = 1'b1; bus.mon_last_out = 1'b1;
                tick();
            end
        end
        idleInputs();
        #1;
        checkEq("wait_hdr_cnt", bus.hdr_cnt, 16'd3);
        checkEq("wait_busy", bus.busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkEq("arst_hdr_cnt", bus.hdr_cnt, 16'd0);
        checkEq("arst_busy", bus.busy, 1'b0);
        checkEq("arst_grant", bus.grant, 2'b00);
        checkEq("arst_valid", bus.valid_insert, 1'b0);
        checkEq("arst_data", bus.data_insert, 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(H, L, 32'h0BADF00D, 32'd0, 4'b0011, 4'd0, 2'd1, 2'd0, L, L, L, L);
        tick();
        idleInputs();
        #1;
        checkEq("post_rst_grant", bus.grant, 2'b01);
        checkEq("post_rst_data", bus.data_insert, 32'h0BADF00D);

        // Random traffic against the packet-level model
        doReset();
        for (int n = 0; n < 3000; n++) begin
            rd0 = $urandom; rd1 = $urandom;
            rc0 = 2'($urandom_range(0, 3)); rc1 = 2'($urandom_range(0, 3));
            rk0 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : maskOf(rc0);
            rk1 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : maskOf(rc1);
            applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                          rd0, rd1, rk0, rk1, rc0, rc1,
                          $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_header_arbiter.md
AXIS_HEADER_ARBITER -- requirements
Module: axis_header_arbiter

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, header/data word width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, byte lanes per word.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), header byte-count width.
REQ-004 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid, req1_valid  in  1 each  requester header offer.
- req0_data, req1_data  in  DATA_WD each  header word.
- req0_keep, req1_keep  in  DATA_BYTE_WD each  header keep.
- req0_byte_cnt, req1_byte_cnt  in  BYTE_CNT_WD each  header valid bytes minus 1.
- req0_ready, req1_ready  out  1 each  header accepted from requester.
- valid_insert  out  1  header offer to the insert block.
- data_insert  out  DATA_WD  header word.
- keep_insert  out  DATA_BYTE_WD  header keep.
- byte_insert_cnt  out  BYTE_CNT_WD  header byte count.
- ready_insert  in  1  insert block accepted the header.
- mon_valid_out, mon_ready_out, mon_last_out  in  1 each  taps of the insert block's output stream.
- grant  out  2  one-hot current packet owner; 00 when idle.
- busy  out  1  high in OFFER or WAIT_EOP.
- hdr_cnt  out  16  count of headers delivered.
- keep_err  out  1  sticky keep/byte_cnt mismatch flag.

Function
REQ-005 SHALL implement FSM IDLE -> OFFER -> WAIT_EOP -> IDLE, with exactly one header granted per output packet.
REQ-006 In IDLE, reqN_ready SHALL be driven combinationally high only for the selected requester, and only while that requester's valid is high; the other ready SHALL be 0.
- Selection: if only one requester is valid, select it; if both are valid, select the requester not granted last (round-robin).
REQ-007 On reqN_valid & reqN_ready at edge n, the block SHALL register data/keep/byte_cnt and set grant[N]; valid_insert SHALL be 1 from cycle n+1, and state SHALL move to OFFER.
REQ-008 In OFFER, valid_insert, data_insert, keep_insert and byte_insert_cnt SHALL hold stable until valid_insert & ready_insert.
- On that handshake: valid_insert SHALL go 0 the next cycle, hdr_cnt SHALL increment by 1, and state SHALL move to WAIT_EOP.
REQ-009 In WAIT_EOP, mon_valid_out & mon_ready_out & mon_last_out SHALL return the block to IDLE next cycle.
- On that return: grant SHALL clear to 00, and the last-granted pointer SHALL update to the owner.
REQ-010 Monitored beats seen in IDLE or OFFER SHALL be ignored; both req_ready SHALL be 0 outside IDLE.
REQ-011 hdr_cnt SHALL wrap from 16'hFFFF to 0 without flagging.
REQ-012 At capture, keep SHALL be checked against the expected mask (1<<(byte_cnt+1))-1, e.g. byte_cnt 1 -> 4'b0011.
- On mismatch: keep_err SHALL set and stay set until reset.
- The header SHALL still be forwarded unchanged.
REQ-013 Data outputs (data_insert, keep_insert, byte_insert_cnt) SHALL be 0 whenever valid_insert is 0.
REQ-014 A requester dropping valid before its ready SHALL not be granted; there SHALL be no combinational path from ready_insert to reqN_ready.

Reset
REQ-015 rst high SHALL asynchronously force: state IDLE, valid_insert 0, data/keep/byte_cnt 0, grant 00, busy 0, hdr_cnt 0, keep_err 0, and the last-granted pointer to req1, so req0 wins the first tie.
REQ-016 rst asserted in OFFER or WAIT_EOP SHALL abandon the packet; after release, the block SHALL start in IDLE with no pending header.

Verification
REQ-017 After reset, req0 offers data 32'hA5A5A5A5, byte_cnt 2, keep 0111 -> req0_ready=1 same cycle; next cycle valid_insert=1, data_insert=A5A5A5A5, grant=01.
REQ-018 ready_insert held 0 for 5 cycles, then 1 -> insert outputs stable for all 6 cycles; valid_insert=0 and hdr_cnt=1 the following cycle.
REQ-019 Both requesters valid for 4 consecutive packets, each ended by a monitored last beat -> grant sequence 01,10,01,10; no second header is offered before each last beat.
REQ-020 A monitored last beat during OFFER, then a real last beat in WAIT_EOP -> the early beat is ignored; IDLE is entered only after the WAIT_EOP beat.
REQ-021 req1 header with byte_cnt 0 and keep 4'b0011 -> keep_err=1 and the header is forwarded unchanged; keep_err remains 1 through later good headers until rst.
REQ-022 rst pulsed while in WAIT_EOP with hdr_cnt=3 -> all outputs 0 immediately, hdr_cnt=0; the next req0 offer is accepted normally.
